// File: rtl/tile_hit_judge.sv
// Piano-tiles hit judge: scores key presses against hit-zone occupancy, tracks
// score/combo/lives/best score and the IDLE/PLAY/OVER game state.
module tile_hit_judge #(
  parameter int LANES     = 4,
  parameter int SCORE_W   = 16,
  parameter int COMBO_W   = 8,
  parameter int LIVES_W   = 2,
  parameter int MAX_LIVES = 3,
  parameter int POINTS    = 1,
  parameter int BONUS_AT  = 10
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [LANES-1:0]   key_pressed,
  input  logic [LANES-1:0]   tile_in_zone,
  input  logic [LANES-1:0]   tile_exit,
  output logic [LANES-1:0]   tile_clear,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] best_score,
  output logic [COMBO_W-1:0] combo,
  output logic [LIVES_W-1:0] lives,
  output logic [1:0]         state,
  output logic               game_over
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_t;

  localparam int CNT_W = $clog2(2*LANES+1);
  localparam int ACC_W = SCORE_W + CNT_W + 8;
  localparam int CMB_W = COMBO_W + CNT_W + 1;

  function automatic logic [SCORE_W-1:0] sat_score(input logic [ACC_W-1:0] v);
    if (v > ACC_W'({SCORE_W{1'b1}})) return '1;
    return v[SCORE_W-1:0];
  endfunction

  function automatic logic [COMBO_W-1:0] sat_combo(input logic [CMB_W-1:0] v);
    if (v > CMB_W'({COMBO_W{1'b1}})) return '1;
    return v[COMBO_W-1:0];
  endfunction

  function automatic logic [LIVES_W-1:0] sub_floor(input logic [LIVES_W-1:0] l,
                                                   input logic [CNT_W-1:0]   p);
    if (int'(p) >= int'(l)) return '0;
    return l - LIVES_W'(p);
  endfunction

  state_t             state_q, state_nxt;
  logic [SCORE_W-1:0] score_p1, best_p1, score_nxt, best_nxt;
  logic [COMBO_W-1:0] combo_p1, combo_nxt;
  logic [LIVES_W-1:0] lives_p1, lives_nxt;
  logic [LANES-1:0]   clear_p1, clear_nxt;
  logic               hit_p1, miss_p1, over_p1;
  logic               hit_nxt, miss_nxt;

  logic [LANES-1:0]   hit_p0, wrong_p0, miss_p0;
  logic [CNT_W-1:0]   hcnt_p0, pcnt_p0;
  logic [ACC_W-1:0]   pts_p0;
  logic [SCORE_W-1:0] score_p0;
  logic [COMBO_W-1:0] combo_p0;
  logic [LIVES_W-1:0] lives_p0;

  // Stage p0: per-lane judgement and candidate PLAY-state updates
  always_comb begin
    hit_p0   = key_pressed & tile_in_zone;
    wrong_p0 = key_pressed & ~tile_in_zone;
    miss_p0  = tile_exit & ~hit_p0;
    hcnt_p0  = '0;
    pcnt_p0  = '0;
    for (int i = 0; i < LANES; i++) begin
      hcnt_p0 = hcnt_p0 + CNT_W'(hit_p0[i]);
      pcnt_p0 = pcnt_p0 + CNT_W'(wrong_p0[i]) + CNT_W'(miss_p0[i]);
    end
    // Bonus rate is chosen from the combo before this cycle's hits land
    pts_p0   = (int'(combo_p1) >= BONUS_AT) ? ACC_W'(2*POINTS) : ACC_W'(POINTS);
    score_p0 = sat_score(ACC_W'(score_p1) + ACC_W'(hcnt_p0) * pts_p0);
    combo_p0 = (pcnt_p0 != '0) ? '0 : sat_combo(CMB_W'(combo_p1) + CMB_W'(hcnt_p0));
    lives_p0 = sub_floor(lives_p1, pcnt_p0);
  end

  always_comb begin
    state_nxt = state_q;
    score_nxt = score_p1;
    best_nxt  = best_p1;
    combo_nxt = combo_p1;
    lives_nxt = lives_p1;
    clear_nxt = '0;
    hit_nxt   = 1'b0;
    miss_nxt  = 1'b0;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_nxt = S_PLAY;
          score_nxt = '0;
          combo_nxt = '0;
          lives_nxt = LIVES_W'(MAX_LIVES);
        end
      end
      S_PLAY: begin
        if (start) begin
          score_nxt = '0;
          combo_nxt = '0;
          lives_nxt = LIVES_W'(MAX_LIVES);
        end else begin
          score_nxt = score_p0;
          combo_nxt = combo_p0;
          lives_nxt = lives_p0;
          clear_nxt = hit_p0;
          hit_nxt   = (hcnt_p0 != '0);
          miss_nxt  = (pcnt_p0 != '0);
          if (lives_p0 == '0) begin
            state_nxt = S_OVER;
            best_nxt  = (score_p0 > best_p1) ? score_p0 : best_p1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage p1: registered outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      score_p1 <= '0;
      best_p1  <= '0;
      combo_p1 <= '0;
      lives_p1 <= '0;
      clear_p1 <= '0;
      hit_p1   <= 1'b0;
      miss_p1  <= 1'b0;
      over_p1  <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      score_p1 <= score_nxt;
      best_p1  <= best_nxt;
      combo_p1 <= combo_nxt;
      lives_p1 <= lives_nxt;
      clear_p1 <= clear_nxt;
      hit_p1   <= hit_nxt;
      miss_p1  <= miss_nxt;
      over_p1  <= (state_nxt == S_OVER);
    end
  end

  assign state      = state_q;
  assign score      = score_p1;
  assign best_score = best_p1;
  assign combo      = combo_p1;
  assign lives      = lives_p1;
  assign tile_clear = clear_p1;
  assign hit_pulse  = hit_p1;
  assign miss_pulse = miss_p1;
  assign game_over  = over_p1;

endmodule
